// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Bridges the MEM pipeline stage and data_memory. Translates a
//             load/store request into data_memory signalling, positions store
//             data in the byte lanes, extends load results, and splits
//             misaligned accesses into several memory cycles while stalling
//             the pipeline through busy.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset        : clock, synchronous active-high reset
//    req_valid         : request present (held while busy)
//    req_is_store      : 1 = store, 0 = load
//    req_func3         : RISC-V load/store func3
//    req_address       : byte address (taken modulo DATA_RAM_DEPTH)
//    req_store_data    : unshifted rs2 value
//    busy              : unit is mid-operation, pipeline must stall
//    resp_valid        : one-cycle completion pulse
//    load_data         : extended load result, valid with resp_valid
//    fault             : illegal func3 / disallowed misaligned access
//    mem_byte_address  : data_memory byte address
//    mem_store_func3   : data_memory store width
//    mem_write_enable  : data_memory write strobe
//    mem_write_data    : lane-positioned store data
//    mem_read_data     : data_memory combinational word read
// ============================================================================
module load_store_unit #(
  parameter int DATA_RAM_DEPTH   = 1024,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  input  logic                              req_is_store,
  input  logic [2:0]                        req_func3,
  input  logic [31:0]                       req_address,
  input  logic [31:0]                       req_store_data,
  output logic                              busy,
  output logic                              resp_valid,
  output logic [31:0]                       load_data,
  output logic                              fault,
  output logic [$clog2(DATA_RAM_DEPTH)-1:0] mem_byte_address,
  output logic [2:0]                        mem_store_func3,
  output logic                              mem_write_enable,
  output logic [31:0]                       mem_write_data,
  input  logic [31:0]                       mem_read_data
);

  localparam int AW = $clog2(DATA_RAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_HI    = 2'd1,
    ST_BYTES = 2'd2
  } state_t;

  state_t        state_q,      state_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   load_data_q,  load_data_d;
  logic          fault_q,      fault_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic [2:0]    func3_q,      func3_d;
  logic [31:0]   lo_word_q,    lo_word_d;
  logic [31:0]   st_data_q,    st_data_d;
  logic [1:0]    byte_cnt_q,   byte_cnt_d;
  logic [1:0]    byte_last_q,  byte_last_d;

  logic          write_en;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_off;
  logic          is_half, is_word;
  logic          illegal, misaligned, fault_req, split;
  logic [31:0]   rd_shift, hi_shift;
  logic [7:0]    st_byte;
  logic          unused_addr_bits;

  assign req_addr         = req_address[AW-1:0];
  assign req_off          = req_addr[1:0];
  assign unused_addr_bits = ^req_address[31:AW];

  assign is_half = (req_func3[1:0] == 2'b01);
  assign is_word = (req_func3[1:0] == 2'b10);

  // Loads allow 000,001,010,100,101; stores only 000,001,010.
  assign illegal = req_is_store ? (req_func3[2] || req_func3[1:0] == 2'b11)
                                : (req_func3 == 3'b011 || req_func3[2:1] == 2'b11);

  assign misaligned = (is_half && req_off == 2'd3) || (is_word && req_off != 2'd0);
  assign fault_req  = illegal || (misaligned && !ALLOW_MISALIGNED);
  assign split      = !illegal && misaligned && ALLOW_MISALIGNED;

  // Memory returns the whole word containing the address; shift the wanted
  // bytes down to bit 0 before extension.
  assign rd_shift = mem_read_data >> {req_off, 3'b000};
  assign hi_shift = 32'({mem_read_data, lo_word_q} >> {addr_q[1:0], 3'b000});
  assign st_byte  = 8'(st_data_q >> {byte_cnt_q, 3'b000});

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'd0, w[7:0]};
      3'b101:  extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    state_d          = state_q;
    resp_valid_d     = 1'b0;
    load_data_d      = load_data_q;
    fault_d          = 1'b0;
    addr_d           = addr_q;
    func3_d          = func3_q;
    lo_word_d        = lo_word_q;
    st_data_d        = st_data_q;
    byte_cnt_d       = byte_cnt_q;
    byte_last_d      = byte_last_q;
    write_en         = 1'b0;
    mem_byte_address = req_addr;
    mem_store_func3  = req_func3;
    mem_write_data   = req_store_data;

    case (state_q)
      IDLE: begin
        if (req_func3[1:0] == 2'b00)
          mem_write_data = {4{req_store_data[7:0]}};
        else if (req_func3[1:0] == 2'b01)
          mem_write_data = {2{req_store_data[15:0]}};

        if (req_valid) begin
          if (fault_req) begin
            resp_valid_d = 1'b1;
            fault_d      = 1'b1;
            load_data_d  = 32'd0;
          end else if (req_is_store) begin
            write_en = 1'b1;
            if (split) begin
              // First byte goes out now; the rest follow from ST_BYTES.
              mem_store_func3 = 3'b000;
              mem_write_data  = {4{req_store_data[7:0]}};
              addr_d          = req_addr;
              st_data_d       = req_store_data;
              byte_cnt_d      = 2'd1;
              byte_last_d     = is_word ? 2'd3 : 2'd1;
              state_d         = ST_BYTES;
            end else begin
              resp_valid_d = 1'b1;
              load_data_d  = 32'd0;
            end
          end else begin
            if (split) begin
              mem_byte_address = {req_addr[AW-1:2], 2'b00};
              lo_word_d        = mem_read_data;
              addr_d           = req_addr;
              func3_d          = req_func3;
              state_d          = LD_HI;
            end else begin
              resp_valid_d = 1'b1;
              load_data_d  = extend(req_func3, rd_shift);
            end
          end
        end
      end

      LD_HI: begin
        mem_byte_address = {addr_q[AW-1:2], 2'b00} + AW'(4);
        load_data_d      = extend(func3_q, hi_shift);
        resp_valid_d     = 1'b1;
        state_d          = IDLE;
      end

      ST_BYTES: begin
        mem_byte_address = addr_q + AW'(byte_cnt_q);
        mem_store_func3  = 3'b000;
        mem_write_data   = {4{st_byte}};
        write_en         = 1'b1;
        byte_cnt_d       = byte_cnt_q + 2'd1;
        if (byte_cnt_q == byte_last_q) begin
          resp_valid_d = 1'b1;
          load_data_d  = 32'd0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // A reset arriving mid-store must suppress the byte of that cycle.
  assign mem_write_enable = write_en && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      load_data_q  <= 32'd0;
      fault_q      <= 1'b0;
      addr_q       <= '0;
      func3_q      <= 3'd0;
      lo_word_q    <= 32'd0;
      st_data_q    <= 32'd0;
      byte_cnt_q   <= 2'd0;
      byte_last_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      load_data_q  <= load_data_d;
      fault_q      <= fault_d;
      addr_q       <= addr_d;
      func3_q      <= func3_d;
      lo_word_q    <= lo_word_d;
      st_data_q    <= st_data_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_last_q  <= byte_last_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign load_data  = load_data_q;
  assign fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit with a
//             byte-addressed data_memory model and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_is_store;
  logic [2:0]  req_func3;
  logic [31:0] req_address, req_store_data;
  logic        busy, resp_valid, fault;
  logic [31:0] load_data;
  logic [9:0]  mem_byte_address;
  logic [2:0]  mem_store_func3;
  logic        mem_write_enable;
  logic [31:0] mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_RAM_DEPTH(1024), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_is_store     (req_is_store),
    .req_func3        (req_func3),
    .req_address      (req_address),
    .req_store_data   (req_store_data),
    .busy             (busy),
    .resp_valid       (resp_valid),
    .load_data        (load_data),
    .fault            (fault),
    .mem_byte_address (mem_byte_address),
    .mem_store_func3  (mem_store_func3),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // ---------------- data_memory model ----------------
  logic [7:0]  mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  function automatic logic [7:0] lane(input logic [31:0] d, input logic [1:0] i);
    return d[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rd_word(input logic [9:0] a);
    return {mem[{a[9:2], 2'd3}], mem[{a[9:2], 2'd2}], mem[{a[9:2], 2'd1}], mem[{a[9:2], 2'd0}]};
  endfunction

  always_comb mem_read_data = rd_word(mem_byte_address);

  always @(posedge clk) begin
    if (pl_en) begin
      mem[{pl_addr[9:2], 2'd0}] <= pl_data[7:0];
      mem[{pl_addr[9:2], 2'd1}] <= pl_data[15:8];
      mem[{pl_addr[9:2], 2'd2}] <= pl_data[23:16];
      mem[{pl_addr[9:2], 2'd3}] <= pl_data[31:24];
    end else if (mem_write_enable) begin
      case (mem_store_func3)
        3'b000: mem[mem_byte_address] <= lane(mem_write_data, mem_byte_address[1:0]);
        3'b001: begin
          mem[mem_byte_address]         <= lane(mem_write_data, mem_byte_address[1:0]);
          mem[mem_byte_address + 10'd1] <= lane(mem_write_data, mem_byte_address[1:0] + 2'd1);
        end
        3'b010: begin
          mem[{mem_byte_address[9:2], 2'd0}] <= mem_write_data[7:0];
          mem[{mem_byte_address[9:2], 2'd1}] <= mem_write_data[15:8];
          mem[{mem_byte_address[9:2], 2'd2}] <= mem_write_data[23:16];
          mem[{mem_byte_address[9:2], 2'd3}] <= mem_write_data[31:24];
        end
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        flt;
  } exp_t;
  exp_t sb_q[$];

  logic [9:0]  addr_log  [0:7];
  logic        we_log    [0:7];
  logic [31:0] wdata_log [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request in cycle T and follows it to its response,
  // checking busy each cycle and logging memory-side activity per cycle.
  task automatic do_req(input string tag, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_ld, input bit exp_f, input int lat);
    exp_t e;
    int   k;
    bit   done;
    for (int i = 0; i < 8; i++) begin
      addr_log[i] = 'x; we_log[i] = 1'bx; wdata_log[i] = 'x;
    end
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_func3 = f3;
    req_address = a; req_store_data = d;
    e.data = exp_ld; e.flt = exp_f;
    sb_q.push_back(e);
    #1;
    addr_log[0] = mem_byte_address; we_log[0] = mem_write_enable; wdata_log[0] = mem_write_data;
    check({tag, " busy_T"}, 32'(busy), 32'd0);
    k = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (k < 8) begin
        addr_log[k] = mem_byte_address; we_log[k] = mem_write_enable; wdata_log[k] = mem_write_data;
      end
      if (resp_valid) begin
        done = 1'b1;
        req_valid = 1'b0;
        e = sb_q.pop_front();
        check({tag, " load_data"}, load_data, e.data);
        check({tag, " fault"}, 32'(fault), 32'(e.flt));
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " busy_resp"}, 32'(busy), 32'd0);
      end else if (k >= 12) begin
        done = 1'b1;
        req_valid = 1'b0;
        void'(sb_q.pop_front());
        check({tag, " timeout_latency"}, 32'(k), 32'(lat));
      end else begin
        check({tag, " busy_mid"}, 32'(busy), 32'd1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_func3 = 3'd0;
    req_address = '0; req_store_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst mem_we", 32'(mem_write_enable), 32'd0);
    reset = 1'b0;

    preload(10'h000, 32'h44332211);
    preload(10'h004, 32'h88776655);

    // Aligned and misaligned loads
    do_req("lw_004", 1'b0, 3'b010, 32'h004, 32'h0, 32'h88776655, 1'b0, 1);
    do_req("lw_002", 1'b0, 3'b010, 32'h002, 32'h0, 32'h66554433, 1'b0, 2);
    do_req("lh_003", 1'b0, 3'b001, 32'h003, 32'h0, 32'h00005544, 1'b0, 2);
    check("lh_003 we_hi", 32'(we_log[1]), 32'd0);
    do_req("lb_007", 1'b0, 3'b000, 32'h007, 32'h0, 32'hFFFFFF88, 1'b0, 1);
    do_req("lbu_007", 1'b0, 3'b100, 32'h007, 32'h0, 32'h00000088, 1'b0, 1);

    // Aligned stores
    do_req("sb_006", 1'b1, 3'b000, 32'h006, 32'h000000EE, 32'h0, 1'b0, 1);
    check("sb_006 wdata", wdata_log[0], 32'hEEEEEEEE);
    check("sb_006 we", 32'(we_log[0]), 32'd1);
    check("sb_006 word1", rd_word(10'h004), 32'h88EE6655);
    do_req("sh_002", 1'b1, 3'b001, 32'h002, 32'h0000BEEF, 32'h0, 1'b0, 1);
    check("sh_002 wdata", wdata_log[0], 32'hBEEFBEEF);
    check("sh_002 word0", rd_word(10'h000), 32'hBEEF2211);
    do_req("lhu_002", 1'b0, 3'b101, 32'h002, 32'h0, 32'h0000BEEF, 1'b0, 1);
    do_req("lh_002", 1'b0, 3'b001, 32'h002, 32'h0, 32'hFFFFBEEF, 1'b0, 1);

    // Misaligned word store, byte-serial
    preload(10'h000, 32'h44332211);
    preload(10'h004, 32'h88776655);
    do_req("sw_001", 1'b1, 3'b010, 32'h001, 32'hAABBCCDD, 32'h0, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_001 addr%0d", i), 32'(addr_log[i]), 32'(i + 1));
      check($sformatf("sw_001 we%0d", i), 32'(we_log[i]), 32'd1);
    end
    check("sw_001 wdata3", wdata_log[3], 32'hAAAAAAAA);
    check("sw_001 word0", rd_word(10'h000), 32'hBBCCDD11);
    check("sw_001 word1", rd_word(10'h004), 32'h887766AA);

    // Wrap-around misaligned load and illegal func3
    preload(10'h3FC, 32'hDDCCBBAA);
    preload(10'h000, 32'h44332211);
    do_req("lw_3fe", 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h2211DDCC, 1'b0, 2);
    check("lw_3fe addrA", 32'(addr_log[0]), 32'h3FC);
    check("lw_3fe addrB", 32'(addr_log[1]), 32'h000);
    do_req("ld_f011", 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 1'b1, 1);
    check("ld_f011 we", 32'(we_log[0]), 32'd0);
    do_req("st_f011", 1'b1, 3'b011, 32'h000, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    check("st_f011 we", 32'(we_log[0]), 32'd0);
    check("st_f011 word0", rd_word(10'h000), 32'h44332211);

    // Reset in the middle of a byte-serial store
    preload(10'h000, 32'h44332211);
    preload(10'h004, 32'h88776655);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_func3 = 3'b010;
    req_address = 32'h001; req_store_data = 32'hAABBCCDD;
    @(posedge clk); @(negedge clk);
    check("rst_mid busy_T1", 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid we_T2", 32'(mem_write_enable), 32'd0);
    @(posedge clk); @(negedge clk);
    check("rst_mid busy_T3", 32'(busy), 32'd0);
    check("rst_mid resp_T3", 32'(resp_valid), 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_mid resp_T4", 32'(resp_valid), 32'd0);
    check("rst_mid word0", rd_word(10'h000), 32'h44CCDD11);
    check("rst_mid word1", rd_word(10'h004), 32'h88776655);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
